// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard and forwarding controller.
package pipe_hazard_pkg;

   // Widest register address the stage entries can hold; narrower addresses are zero-extended.
   localparam int RD_MAX_W = 8;

   localparam int FWD_RF = 0;

   typedef struct packed {
      logic                valid;
      logic [RD_MAX_W-1:0] rd;
      logic                reg_write;
      logic                mem_read;
   } stage_entry_t;

   function automatic int sel_w(input int stages);
      return $clog2(stages + 1);
   endfunction

   function automatic logic is_producer(input stage_entry_t e);
      return e.valid && e.reg_write && (e.rd != '0);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// hazard_src_match: finds the youngest in-flight producer of one source operand
// and reports whether that producer is a load whose data is not yet available.
module hazard_src_match
   import pipe_hazard_pkg::*;
#(
   parameter int STAGES     = 3,
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_STAGE = 3,
   parameter int SEL_W      = sel_w(STAGES)
) (
   input  logic [REG_ADDR_W-1:0]   rs,
   input  logic                    rs_used,
   input  stage_entry_t [STAGES-2:0] stage,
   output logic [SEL_W-1:0]        match_stage,
   output logic                    load_use
);

   int   win_j;
   logic win_load;

   // Scan oldest to youngest so the youngest producer overwrites any older match.
   always_comb begin
      win_j    = 0;
      win_load = 1'b0;
      if (rs_used && (rs != '0)) begin
         for (int j = STAGES - 1; j >= 1; j--) begin
            if (is_producer(stage[j-1]) && (stage[j-1].rd == RD_MAX_W'(rs))) begin
               win_j    = j;
               win_load = stage[j-1].mem_read;
            end
         end
      end
   end

   assign match_stage = SEL_W'(win_j);
   assign load_use    = win_load && ((win_j + 1) < LOAD_STAGE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: stage metadata shift register, load-use stall,
// branch flush and registered forwarding selects. Optional counters: PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
   import pipe_hazard_pkg::*;
#(
   parameter  int STAGES     = 3,
   parameter  int NUM_SRC    = 2,
   parameter  int REG_ADDR_W = 5,
   parameter  int LOAD_STAGE = 3,
   localparam int SEL_W      = sel_w(STAGES)
) (
   input  logic                          clk,
   input  logic                          arst_n,
   input  logic                          enable,
   input  logic                          id_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
   input  logic [NUM_SRC-1:0]            id_rs_used,
   input  logic [REG_ADDR_W-1:0]         id_rd,
   input  logic                          id_reg_write,
   input  logic                          id_mem_read,
   input  logic                          ex_branch_taken,
   output logic                          stall_id,
   output logic                          flush_if_id,
   output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_ex,
   output logic [STAGES-1:0]             stage_valid,
   output logic [31:0]                   stall_cnt,
   output logic [31:0]                   flush_cnt
);

   // The last stage is never matched (write-through register file), so only its valid bit is kept.
   stage_entry_t [STAGES-2:0] stage_q;
   logic                      last_valid_q;

   stage_entry_t              id_entry;
   logic [NUM_SRC-1:0]        load_use;
   logic [SEL_W-1:0]          match_stage [NUM_SRC];
   logic [NUM_SRC*SEL_W-1:0]  sel_next;
   logic                      hazard;
   logic                      advance;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      hazard_src_match #(
         .STAGES     (STAGES),
         .REG_ADDR_W (REG_ADDR_W),
         .LOAD_STAGE (LOAD_STAGE),
         .SEL_W      (SEL_W)
      ) u_match (
         .rs          (id_rs[i*REG_ADDR_W +: REG_ADDR_W]),
         .rs_used     (id_rs_used[i]),
         .stage       (stage_q),
         .match_stage (match_stage[i]),
         .load_use    (load_use[i])
      );
   end

   assign hazard      = |load_use;
   assign stall_id    = id_valid & hazard & ~ex_branch_taken;
   assign flush_if_id = ex_branch_taken & stage_q[0].valid;
   assign advance     = id_valid & ~stall_id & ~flush_if_id;

   always_comb begin
      id_entry = '0;
      if (advance) begin
         id_entry.valid     = 1'b1;
         id_entry.rd        = RD_MAX_W'(id_rd);
         id_entry.reg_write = id_reg_write;
         id_entry.mem_read  = id_mem_read;
      end
   end

   // A match in stage j is one stage older by the time the consumer reaches EX.
   always_comb begin
      sel_next = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         sel_next[i*SEL_W +: SEL_W] = SEL_W'(FWD_RF);
         if (advance && (match_stage[i] != '0)) begin
            sel_next[i*SEL_W +: SEL_W] = match_stage[i] + SEL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         stage_q      <= '0;
         last_valid_q <= 1'b0;
         fwd_sel_ex   <= '0;
      end else if (enable) begin
         last_valid_q <= stage_q[STAGES-2].valid;
         for (int k = STAGES - 2; k >= 1; k--) begin
            stage_q[k] <= stage_q[k-1];
         end
         stage_q[0]   <= id_entry;
         fwd_sel_ex   <= sel_next;
      end
   end

   always_comb begin
      stage_valid = '0;
      for (int k = 0; k < STAGES - 1; k++) begin
         stage_valid[k] = stage_q[k].valid;
      end
      stage_valid[STAGES-1] = last_valid_q;
   end

`ifdef PIPE_HAZARD_PERF_EN
   // Saturating event counters; frozen along with the rest of the state when enable is low.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (enable) begin
         if (stall_id && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (flush_if_id && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a default instance and a STAGES=5/LOAD_STAGE=4
// instance share the ID inputs and are each checked against an instruction-level model.
module tb_pipe_hazard_ctrl;

   localparam int NUM_SRC = 2;
   localparam int RW      = 5;
   localparam int S_A = 3, L_A = 3, SW_A = 2;
   localparam int S_B = 5, L_B = 4, SW_B = 3;

`ifdef PIPE_HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    arst_n = 1'b0;
   logic                    enable = 1'b1;
   logic                    id_valid = 1'b0;
   logic [NUM_SRC*RW-1:0]   id_rs = '0;
   logic [NUM_SRC-1:0]      id_rs_used = '0;
   logic [RW-1:0]           id_rd = '0;
   logic                    id_reg_write = 1'b0;
   logic                    id_mem_read = 1'b0;
   logic                    ex_branch_taken = 1'b0;

   logic                    stall_a, flush_a, stall_b, flush_b;
   logic [NUM_SRC*SW_A-1:0] fwd_a;
   logic [NUM_SRC*SW_B-1:0] fwd_b;
   logic [S_A-1:0]          sv_a;
   logic [S_B-1:0]          sv_b;
   logic [31:0]             sc_a, fc_a, sc_b, fc_b;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.STAGES(S_A), .NUM_SRC(NUM_SRC), .REG_ADDR_W(RW), .LOAD_STAGE(L_A)) dut_a (
      .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid), .id_rs(id_rs),
      .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken), .stall_id(stall_a),
      .flush_if_id(flush_a), .fwd_sel_ex(fwd_a), .stage_valid(sv_a), .stall_cnt(sc_a),
      .flush_cnt(fc_a)
   );

   pipe_hazard_ctrl #(.STAGES(S_B), .NUM_SRC(NUM_SRC), .REG_ADDR_W(RW), .LOAD_STAGE(L_B)) dut_b (
      .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid), .id_rs(id_rs),
      .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken), .stall_id(stall_b),
      .flush_if_id(flush_b), .fwd_sel_ex(fwd_b), .stage_valid(sv_b), .stall_cnt(sc_b),
      .flush_cnt(fc_b)
   );

   // Model: one in-flight instruction record per pipeline position, index 1 = EX.
   typedef struct {
      bit v;
      int rd;
      bit we;
      bit ld;
   } ent_t;

   ent_t   pipe      [2][8];
   int     sel_q     [2][NUM_SRC];
   int     sel_nx    [2][NUM_SRC];
   bit     exp_stall [2];
   bit     exp_flush [2];
   bit     exp_adv   [2];
   longint cnt_stall [2];
   longint cnt_flush [2];
   logic   obs_stall [2];
   logic   obs_flush [2];
   int     stalls    [2];
   int     first_sel [2];

   int checks = 0;
   int fails  = 0;

   function automatic int depth_of(input int d);
      return (d == 0) ? S_A : S_B;
   endfunction

   function automatic int lstage_of(input int d);
      return (d == 0) ? L_A : L_B;
   endfunction

   function automatic logic [31:0] get_sel(input int d, input int i);
      return (d == 0) ? 32'(fwd_a[i*SW_A +: SW_A]) : 32'(fwd_b[i*SW_B +: SW_B]);
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear(input int d);
      for (int k = 0; k < 8; k++) begin
         pipe[d][k].v  = 1'b0;
         pipe[d][k].rd = 0;
         pipe[d][k].we = 1'b0;
         pipe[d][k].ld = 1'b0;
      end
      for (int i = 0; i < NUM_SRC; i++) sel_q[d][i] = 0;
      cnt_stall[d] = 0;
      cnt_flush[d] = 0;
   endtask

   task automatic model_eval(input int d);
      bit hz;
      hz = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         int src;
         int best;
         src  = int'(id_rs[i*RW +: RW]);
         best = 0;
         if (id_rs_used[i] && src != 0) begin
            for (int j = 1; j < depth_of(d); j++) begin
               if (best == 0 && pipe[d][j].v && pipe[d][j].we && pipe[d][j].rd == src) best = j;
            end
         end
         if (best != 0 && pipe[d][best].ld && best + 1 < lstage_of(d)) hz = 1'b1;
         sel_nx[d][i] = (best == 0) ? 0 : best + 1;
      end
      exp_stall[d] = id_valid && hz && !ex_branch_taken;
      exp_flush[d] = ex_branch_taken && pipe[d][1].v;
      exp_adv[d]   = id_valid && !exp_stall[d] && !exp_flush[d];
   endtask

   task automatic model_edge(input int d);
      if (!arst_n) begin
         model_clear(d);
      end else if (enable) begin
         for (int k = depth_of(d); k >= 2; k--) pipe[d][k] = pipe[d][k-1];
         pipe[d][1].v  = exp_adv[d];
         pipe[d][1].rd = exp_adv[d] ? int'(id_rd) : 0;
         pipe[d][1].we = exp_adv[d] && id_reg_write;
         pipe[d][1].ld = exp_adv[d] && id_mem_read;
         for (int i = 0; i < NUM_SRC; i++) sel_q[d][i] = exp_adv[d] ? sel_nx[d][i] : 0;
         if (PERF && exp_stall[d] && cnt_stall[d] < 64'hFFFF_FFFF) cnt_stall[d]++;
         if (PERF && exp_flush[d] && cnt_flush[d] < 64'hFFFF_FFFF) cnt_flush[d]++;
      end
   endtask

   task automatic check_regs(input int d);
      logic [31:0] ev;
      ev = '0;
      for (int k = 1; k <= depth_of(d); k++) ev[k-1] = pipe[d][k].v;
      check_output($sformatf("stage_valid_%0d", d), (d == 0) ? 32'(sv_a) : 32'(sv_b), ev);
      for (int i = 0; i < NUM_SRC; i++) begin
         check_output($sformatf("fwd_sel_%0d_op%0d", d, i), get_sel(d, i), 32'(sel_q[d][i]));
      end
      check_output($sformatf("stall_cnt_%0d", d), (d == 0) ? sc_a : sc_b, 32'(cnt_stall[d]));
      check_output($sformatf("flush_cnt_%0d", d), (d == 0) ? fc_a : fc_b, 32'(cnt_flush[d]));
   endtask

   // One clock: check the combinational outputs mid-cycle, then the registered ones after the edge.
   task automatic apply_stimulus();
      #2;
      for (int d = 0; d < 2; d++) begin
         model_eval(d);
         obs_stall[d] = (d == 0) ? stall_a : stall_b;
         obs_flush[d] = (d == 0) ? flush_a : flush_b;
         check_output($sformatf("stall_id_%0d", d), 32'(obs_stall[d]), 32'(exp_stall[d]));
         check_output($sformatf("flush_if_id_%0d", d), 32'(obs_flush[d]), 32'(exp_flush[d]));
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         model_edge(d);
         check_regs(d);
      end
   endtask

   task automatic set_id(input bit v, input int rd, input bit we, input bit ld,
                         input int r0, input int r1, input bit u0, input bit u1);
      id_valid        = v;
      id_rd           = RW'(rd);
      id_reg_write    = we;
      id_mem_read     = ld;
      id_rs           = {RW'(r1), RW'(r0)};
      id_rs_used      = {u1, u0};
   endtask

   task automatic idle(input int n);
      set_id(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      repeat (n) apply_stimulus();
   endtask

   // Present one instruction and hold it in ID until neither instance stalls it.
   task automatic issue(input int rd, input bit we, input bit ld,
                        input int r0, input int r1, input bit u0, input bit u1);
      bit done [2];
      set_id(1'b1, rd, we, ld, r0, r1, u0, u1);
      for (int d = 0; d < 2; d++) begin
         done[d]      = 1'b0;
         stalls[d]    = 0;
         first_sel[d] = -1;
      end
      for (int n = 0; n < 6 && !(done[0] && done[1]); n++) begin
         apply_stimulus();
         for (int d = 0; d < 2; d++) begin
            if (!done[d]) begin
               if (obs_stall[d] === 1'b1) begin
                  stalls[d]++;
               end else begin
                  done[d]      = 1'b1;
                  first_sel[d] = int'(get_sel(d, 0));
               end
            end
         end
      end
      check_output("issue_bound", 32'(done[0] && done[1]), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      model_clear(0);
      model_clear(1);
      @(posedge clk);
      #1;
      repeat (2) apply_stimulus();
      check_output("reset_sv_a", 32'(sv_a), 32'd0);
      check_output("reset_fwd_b", 32'(fwd_b), 32'd0);
      arst_n = 1'b1;

      // Load immediately followed by a dependent instruction.
      issue(5, 1, 1, 0, 0, 0, 0);
      issue(6, 1, 0, 5, 1, 1, 1);
      check_output("lu_stalls_a", 32'(stalls[0]), 32'd1);
      check_output("lu_stalls_b", 32'(stalls[1]), 32'd2);
      check_output("lu_sel_a", 32'(first_sel[0]), 32'd3);
      check_output("lu_sel_b", 32'(first_sel[1]), 32'd4);

      // Load two instructions ahead of its consumer.
      idle(6);
      issue(7, 1, 1, 0, 0, 0, 0);
      issue(8, 1, 0, 0, 0, 0, 0);
      issue(9, 1, 0, 7, 0, 1, 0);
      check_output("lu2_stalls_a", 32'(stalls[0]), 32'd0);
      check_output("lu2_stalls_b", 32'(stalls[1]), 32'd1);
      check_output("lu2_sel_a", 32'(first_sel[0]), 32'd3);
      check_output("lu2_sel_b", 32'(first_sel[1]), 32'd4);

      // Youngest producer wins; an older load is shadowed by a younger ALU write.
      idle(6);
      issue(5, 1, 0, 0, 0, 0, 0);
      issue(5, 1, 0, 0, 0, 0, 0);
      issue(10, 1, 0, 5, 0, 1, 0);
      check_output("prio_sel_a", 32'(first_sel[0]), 32'd2);
      check_output("prio_sel_b", 32'(first_sel[1]), 32'd2);
      idle(6);
      issue(5, 1, 1, 0, 0, 0, 0);
      issue(5, 1, 0, 0, 0, 0, 0);
      issue(10, 1, 0, 5, 0, 1, 0);
      check_output("shadow_stalls_b", 32'(stalls[1]), 32'd0);
      check_output("shadow_sel_b", 32'(first_sel[1]), 32'd2);
      idle(6);
      issue(0, 1, 0, 0, 0, 0, 0);
      issue(11, 1, 0, 0, 0, 1, 0);
      check_output("x0_sel_a", 32'(first_sel[0]), 32'd0);

      // Branch taken while a load-use hazard is pending: flush wins.
      idle(6);
      issue(9, 1, 1, 0, 0, 0, 0);
      set_id(1'b1, 12, 1'b1, 1'b0, 9, 0, 1'b1, 1'b0);
      ex_branch_taken = 1'b1;
      apply_stimulus();
      check_output("flush_stall_a", 32'(obs_stall[0]), 32'd0);
      check_output("flush_flush_a", 32'(obs_flush[0]), 32'd1);
      check_output("flush_bubble_a", 32'(sv_a[0]), 32'd0);
      ex_branch_taken = 1'b0;

      // Freeze mid-stream with a stalling instruction in ID.
      idle(6);
      issue(13, 1, 1, 0, 0, 0, 0);
      set_id(1'b1, 14, 1'b1, 1'b0, 13, 0, 1'b1, 1'b0);
      enable = 1'b0;
      repeat (4) apply_stimulus();
      enable = 1'b1;
      issue(14, 1, 0, 13, 0, 1, 0);
      check_output("freeze_sel_a", 32'(first_sel[0]), 32'd3);

      // Reset while stalled.
      idle(6);
      issue(3, 1, 1, 0, 0, 0, 0);
      set_id(1'b1, 4, 1'b1, 1'b0, 3, 0, 1'b1, 1'b0);
      apply_stimulus();
      arst_n = 1'b0;
      apply_stimulus();
      check_output("rst_sv_a", 32'(sv_a), 32'd0);
      check_output("rst_fwd_a", 32'(fwd_a), 32'd0);
      check_output("rst_cnt_a", sc_a, 32'd0);
      arst_n = 1'b1;
      apply_stimulus();
      check_output("rst_nohaz_a", 32'(obs_stall[0]), 32'd0);

      // Randomised traffic.
      for (int n = 0; n < 400; n++) begin
         set_id($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         enable          = ($urandom_range(0, 7) != 0);
         arst_n          = ($urandom_range(0, 63) != 0);
         apply_stimulus();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It tracks destination-register metadata for every in-flight instruction past decode, generates load-use stalls and branch flushes, and produces registered per-operand forwarding selects for the execute stage. It generalises the fixed 5-stage, two-operand forwarding logic to configurable depth, operand count and load latency, and adds stall, flush and enable handling.

## Interface
- STAGES, 3: tracked stages after ID (1=EX, 2=MEM, 3=WB); range 2..7
- NUM_SRC, 2: source operands per instruction; range 1..3
- REG_ADDR_W, 5: register address width
- LOAD_STAGE, 3: stage whose pipeline register first holds load data; range 2..STAGES
- clk  in  1  clock
- arst_n  in  1  reset; one clock, reset is synchronous and active-low
- enable  in  1  global pipeline advance; low freezes all state
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  NUM_SRC*REG_ADDR_W  source register addresses; operand i at [i*REG_ADDR_W +: REG_ADDR_W]
- id_rs_used  in  NUM_SRC  operand i actually reads a register
- id_rd  in  REG_ADDR_W  destination register
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  EX instruction redirects the PC (branch or jump taken)
- stall_id  out  1  hold PC and IF/ID, insert bubble into ID/EX (combinational)
- flush_if_id  out  1  kill IF/ID contents (combinational)
- fwd_sel_ex  out  NUM_SRC*SEL_W  registered forwarding select for the instruction now in EX; SEL_W = clog2(STAGES+1)
- stage_valid  out  STAGES  valid bit per tracked stage
- stall_cnt  out  32  stall-cycle counter (see Configuration)
- flush_cnt  out  32  flush-event counter (see Configuration)

## Operation
- Per stage k in 1..STAGES, the block holds valid, rd, reg_write and mem_read. A stage is a producer when valid=1, reg_write=1 and rd≠0.
- Match: for operand i with id_rs_used[i]=1 and id_rs[i]≠0, match stage j in 1..STAGES-1 when stage j is a producer and its rd equals the operand address. The youngest match (smallest j) wins. Stage STAGES is never matched, because the register file is write-through.
- Load-use: if the winning match is a load and j+1 < LOAD_STAGE, set hazard=1. An older matching load is ignored when a younger non-load match exists.
- Forward select for the next EX: j+1 for the winning match, otherwise 0 (register file). Value 1 never occurs.
- stall_id = id_valid & hazard & ~ex_branch_taken.
- flush_if_id = ex_branch_taken & stage_valid[1].
- Advance, on an edge with enable=1:
  - stages shift k to k+1; stage STAGES retires.
  - Stage 1 loads the ID metadata when id_valid & ~stall_id & ~flush_if_id. Otherwise stage 1 loads a bubble (valid=0).
  - fwd_sel_ex is loaded with the computed selects. It is loaded with 0 for a bubble.
- Flush wins over stall: when both occur in the same cycle, the ID instruction is killed rather than held.
- Bubble and killed entries never match and never forward.

## Timing
- Reset (arst_n=0 at an edge) takes priority over enable. It clears all stage state, stage_valid, fwd_sel_ex, stall_cnt and flush_cnt to 0.
- stall_id and flush_if_id: zero latency, combinational from current state and ID inputs.
- fwd_sel_ex: one-cycle latency. It is valid in the cycle the consumer occupies EX.
- Load-use with default parameters (load immediately followed by a dependent instruction): exactly one stall cycle. The select then reads 3.
- With enable=0, all registers hold. stall_id and flush_if_id still reflect the current inputs.
- A reset during a stall or flush discards all in-flight metadata. The first cycle after reset has no hazards.

## Configuration
- PIPE_HAZARD_PERF_EN defined:
  - stall_cnt increments on every enabled cycle with stall_id=1.
  - flush_cnt increments on every enabled cycle with flush_if_id=1.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
- Not defined: both ports are tied to 0 and the counters are not synthesised.

## Structure
- Package pipe_hazard_pkg:
  - SEL_W function (clog2)
  - stage-entry struct typedef (valid, rd, reg_write, mem_read)
  - select constant FWD_RF=0
- Sub-module hazard_src_match, one instance per operand:
  - compares one source against all stages
  - returns the winning stage index and the load-use flag
- Top level holds the stage shift register, the fwd_sel_ex register and the optional counters.

## Test plan
- Load-use: `lw x5` then `add x6,x5,x1` (defaults) → stall_id=1 for exactly one cycle; next cycle EX fwd_sel_ex[op0]=3; stall_cnt=1 with PIPE_HAZARD_PERF_EN.
- Priority: `add x5` followed by `sub x5` and then a consumer of x5 → fwd_sel_ex=2 (youngest producer), not 3. A consumer of x0 with a producer of x0 → sel 0.
- Simultaneous events: load in stage 1 with a dependent instruction in ID, plus ex_branch_taken=1 → stall_id=0, flush_if_id=1, stage 1 becomes a bubble next cycle, flush_cnt=1.
- Enable freeze: hold enable=0 for 4 cycles mid-stream → stage_valid and fwd_sel_ex unchanged and counters static; resuming gives an identical sequence to an unfrozen run.
- Parametrisation: STAGES=5, LOAD_STAGE=4, load at j=1 → two stall cycles, then sel=4; load at j=2 → one stall cycle, then sel=4.
- Reset mid-stall: arst_n=0 for one edge during a load-use stall → all outputs 0 next cycle and stall_cnt=0.
